// File: rtl/remote_comm_pkg.sv
// remote_comm_pkg: shared constants and sequencer state type for the robot command link
package remote_comm_pkg;
    localparam int BAUD_DIV_DEFAULT = 2604;
    localparam int UART_BITS = 10;
    typedef enum logic [2:0] {IDLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO} seq_state_e;
endpackage

// File: rtl/remote_comm_uart.sv
// remote_comm_uart: byte UART tx/rx; REMOTE_COMM_FRAME_CHK_EN drops bytes with a bad stop bit
module remote_comm_uart
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_last,
    input  logic       rx,
    output logic       rx_start,
    output logic       rx_valid,
    output logic [7:0] rx_byte
);
    localparam int BW = $clog2(BAUD_DIV) + 1;
    localparam logic [BW-1:0] BAUD_END = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2);
    localparam logic [3:0] LAST_BIT = 4'(UART_BITS - 1);

    logic [UART_BITS-1:0] tx_sh;
    logic                 tx_busy;
    logic [BW-1:0]        tx_baud;
    logic [3:0]           tx_bit;
    logic                 rx_s1, rx_s2, rx_prev, rx_busy, smp;
    logic [BW-1:0]        rx_baud;
    logic [3:0]           rx_bit;
    logic [7:0]           rx_sh;

    assign tx = tx_sh[0];
    // last clock of the stop bit: a new byte may load here for a gapless follow-on
    assign tx_last = tx_busy && tx_bit == LAST_BIT && tx_baud == BAUD_END;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sh   <= '1;
            tx_busy <= 1'b0;
            tx_baud <= '0;
            tx_bit  <= '0;
        end else if (tx_start && (!tx_busy || tx_last)) begin
            tx_sh   <= {1'b1, tx_data, 1'b0};
            tx_busy <= 1'b1;
            tx_baud <= '0;
            tx_bit  <= '0;
        end else if (tx_busy) begin
            tx_baud <= (tx_baud == BAUD_END) ? '0 : tx_baud + 1'b1;
            if (tx_baud == BAUD_END) begin
                tx_sh   <= {1'b1, tx_sh[UART_BITS-1:1]};
                tx_bit  <= tx_last ? '0 : tx_bit + 1'b1;
                tx_busy <= !tx_last;
            end
        end
    end

    assign smp      = rx_busy && rx_baud == BAUD_END;
    assign rx_start = !rx_busy && rx_prev && !rx_s2;
    assign rx_byte  = rx_sh;
`ifdef REMOTE_COMM_FRAME_CHK_EN
    assign rx_valid = smp && rx_bit == LAST_BIT && rx_s2;
`else
    assign rx_valid = smp && rx_bit == LAST_BIT;
`endif

    // counter preloads to half a bit so every sample lands mid-bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
            rx_busy <= 1'b0;
            rx_baud <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (rx_start) begin
                rx_busy <= 1'b1;
                rx_baud <= BAUD_HALF;
                rx_bit  <= '0;
            end else if (rx_busy) begin
                rx_baud <= smp ? '0 : rx_baud + 1'b1;
                if (smp) begin
                    rx_bit  <= (rx_bit == LAST_BIT) ? '0 : rx_bit + 1'b1;
                    rx_busy <= rx_bit != LAST_BIT;
                    if (rx_bit != 4'd0 && rx_bit != LAST_BIT)
                        rx_sh <= {rx_s2, rx_sh[7:1]};
                end
            end
        end
    end
endmodule

// File: rtl/remote_comm.sv
// remote_comm: two-byte command sender and response receiver; REMOTE_COMM_FRAME_CHK_EN enables stop-bit check
module remote_comm
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        cmd_snt,
    output logic        resp_rdy,
    output logic [7:0]  resp
);
    seq_state_e state;
    logic       tx_start, tx_last, rx_start, rx_valid, accept;
    logic [7:0] tx_data, cmd_lo, rx_byte;

    assign accept = state == IDLE && snd_cmd;

    remote_comm_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk(clk),
        .rst(rst),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx(TX),
        .tx_last(tx_last),
        .rx(RX),
        .rx_start(rx_start),
        .rx_valid(rx_valid),
        .rx_byte(rx_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            cmd_lo   <= '0;
            cmd_snt  <= 1'b0;
        end else begin
            cmd_snt <= 1'b0;
            case (state)
                IDLE: if (snd_cmd) begin
                    tx_data  <= cmd[15:8];
                    cmd_lo   <= cmd[7:0];
                    tx_start <= 1'b1;
                    state    <= SEND_HI;
                end
                SEND_HI: begin
                    tx_start <= 1'b0;
                    state    <= WAIT_HI;
                end
                WAIT_HI: if (tx_last) begin
                    tx_data  <= cmd_lo;
                    tx_start <= 1'b1;
                    state    <= SEND_LO;
                end
                SEND_LO: begin
                    tx_start <= 1'b0;
                    state    <= WAIT_LO;
                end
                WAIT_LO: if (tx_last) begin
                    cmd_snt <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp     <= 8'h00;
            resp_rdy <= 1'b0;
        end else if (rx_valid) begin
            resp     <= rx_byte;
            resp_rdy <= 1'b1;
        end else if (rx_start || accept) begin
            resp_rdy <= 1'b0;
        end
    end
endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm: randomized scoreboard bench; line-level UART models on TX and RX
module tb_remote_comm;
    localparam int B = 16;
`ifdef REMOTE_COMM_FRAME_CHK_EN
    localparam bit FRAME_CHK = 1'b1;
`else
    localparam bit FRAME_CHK = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, RX = 1'b1, snd_cmd = 1'b0;
    logic [15:0] cmd = '0;
    logic        TX, cmd_snt, resp_rdy;
    logic [7:0]  resp;

    remote_comm #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd),
        .snd_cmd(snd_cmd), .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_vec = 0, n_err = 0, busy_until = 0, rx_t0 = 0, snt_e;
    logic [7:0] exp_tx_q[$], exp_resp_q[$];
    int         exp_snt_q[$];
    logic [7:0] last_resp = 8'h00, mon_e, tx_e;
    logic [9:0] tx_bits;
    logic       rdy_prev = 1'b0, tx_ab;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [15:0] c);
        bit acc;
        acc = cyc >= busy_until;
        cmd = c;
        snd_cmd = 1'b1;
        if (acc) begin
            exp_tx_q.push_back(c[15:8]);
            exp_tx_q.push_back(c[7:0]);
            exp_snt_q.push_back(cyc + 20 * B + 2);
            busy_until = cyc + 20 * B + 2;
        end
        tick;
        snd_cmd = 1'b0;
        cmd = 16'($urandom);
        if (acc) begin
            @(negedge clk);
            chk("resp_rdy_clr_on_cmd", resp_rdy, 0);
        end
    endtask

    task automatic drive_rx(input logic [7:0] b, input bit stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        if (stop || !FRAME_CHK) begin
            exp_resp_q.push_back(b);
            last_resp = b;
        end
        rx_t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            RX = fr[i];
            repeat (B) tick;
        end
        RX = 1'b1;
        repeat (2 * B) tick;
    endtask

    task automatic wait_done;
        int n = 0;
        while ((exp_tx_q.size() != 0 || exp_snt_q.size() != 0 || exp_resp_q.size() != 0 ||
                cyc < busy_until) && n < 60 * B) begin
            tick;
            n++;
        end
        chk("drain_timeout", n >= 60 * B, 0);
        repeat (4) tick;
    endtask

    // TX line decoder: mid-bit samples of each frame, compared with queued bytes
    initial forever begin
        @(negedge clk);
        if (!rst && TX === 1'b0) begin
            tx_ab = 1'b0;
            for (int k = 0; k < 10 && !tx_ab; k++) begin
                repeat (k == 0 ? B / 2 : B) begin
                    @(negedge clk);
                    if (rst) tx_ab = 1'b1;
                end
                tx_bits[k] = TX;
            end
            if (!tx_ab) begin
                n_vec++;
                if (exp_tx_q.size() == 0) begin
                    n_err++;
                    $display("FAIL tx_unexpected: got byte 0x%0h, want no frame", tx_bits[8:1]);
                end else begin
                    tx_e = exp_tx_q.pop_front();
                    if (tx_bits[8:1] !== tx_e || tx_bits[0] !== 1'b0 || tx_bits[9] !== 1'b1) begin
                        n_err++;
                        $display("FAIL tx_byte: got frame 0x%0h, want byte 0x%0h framed 0/1", tx_bits, tx_e);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && cmd_snt === 1'b1) begin
            n_vec++;
            if (exp_snt_q.size() == 0) begin
                n_err++;
                $display("FAIL cmd_snt_unexpected: got pulse at cycle %0d, want none", cyc);
            end else begin
                snt_e = exp_snt_q.pop_front();
                if (cyc < snt_e - 2 || cyc > snt_e + 2) begin
                    n_err++;
                    $display("FAIL cmd_snt_time: got cycle %0d, want %0d +-2", cyc, snt_e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && resp_rdy === 1'b1 && !rdy_prev) begin
            n_vec++;
            if (exp_resp_q.size() == 0) begin
                n_err++;
                $display("FAIL resp_unexpected: got resp 0x%0h, want no response", resp);
            end else begin
                mon_e = exp_resp_q.pop_front();
                if (resp !== mon_e || cyc - rx_t0 > 10 * B + 4) begin
                    n_err++;
                    $display("FAIL resp: got 0x%0h after %0d cycles, want 0x%0h within %0d",
                             resp, cyc - rx_t0, mon_e, 10 * B + 4);
                end
            end
        end
        rdy_prev = resp_rdy;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, want finish before cycle 100000");
        $fatal(1);
    end

    initial begin
        logic [15:0] rc;
        logic [7:0]  rb;
        bit          rs;
        int          off;
        repeat (3) tick;
        @(negedge clk);
        chk("reset_tx", TX, 1);
        chk("reset_cmd_snt", cmd_snt, 0);
        chk("reset_resp_rdy", resp_rdy, 0);
        chk("reset_resp", resp, 0);
        tick;
        rst = 1'b0;
        tick;

        send_cmd(16'h2000);
        wait_done;

        send_cmd(16'h4BF2);
        repeat (5 * B) tick;
        send_cmd(16'h6042);
        wait_done;

        drive_rx(8'hA5, 1'b1);
        wait_done;
        chk("resp_a5", resp, 8'hA5);
        chk("resp_rdy_a5", resp_rdy, 1);
        send_cmd(16'($urandom));
        wait_done;

        drive_rx(8'h5A, 1'b0);
        wait_done;
        chk("frame_err_resp", resp, last_resp);
        chk("frame_err_rdy", resp_rdy, !FRAME_CHK);

        fork
            send_cmd(16'h6042);
            begin
                repeat (3 * B) tick;
                drive_rx(8'hA5, 1'b1);
            end
        join
        wait_done;
        chk("concurrent_resp", resp, 8'hA5);

        for (int it = 0; it < 8; it++) begin
            rc  = 16'($urandom);
            rb  = 8'($urandom);
            rs  = $urandom_range(0, 3) != 0;
            off = $urandom_range(1, 8 * B);
            fork
                send_cmd(rc);
                begin
                    repeat (off) tick;
                    drive_rx(rb, rs);
                end
            join
            wait_done;
        end
        chk("resp_final", resp, last_resp);

        send_cmd(16'hC3E1);
        repeat (5 * B) tick;
        rst = 1'b1;
        exp_tx_q.delete();
        exp_snt_q.delete();
        busy_until = 0;
        last_resp = 8'h00;
        tick;
        @(negedge clk);
        chk("midframe_rst_tx", TX, 1);
        chk("midframe_rst_cmd_snt", cmd_snt, 0);
        chk("midframe_rst_resp_rdy", resp_rdy, 0);
        chk("midframe_rst_resp", resp, 0);
        tick;
        rst = 1'b0;
        repeat (25 * B) tick;
        chk("post_rst_tx_idle", TX, 1);
        chk("leftover", exp_tx_q.size() + exp_snt_q.size() + exp_resp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/remote_comm.md
REMOTE_COMM -- requirements
Module: remote_comm

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 2604, meaning clocks per UART bit (19200 baud at 50 MHz).
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port RX  input  1  serial response line from the robot, asynchronous, idles high.
REQ-005 SHALL have port TX  output  1  serial command line to the robot, idles high.
REQ-006 SHALL have port cmd  input  16  command word to send.
REQ-007 SHALL have port snd_cmd  input  1  one-cycle request to send cmd.
REQ-008 SHALL have port cmd_snt  output  1  one-cycle pulse when both command bytes are transmitted.
REQ-009 SHALL have port resp_rdy  output  1  level, a received response byte is valid.
REQ-010 SHALL have port resp  output  8  last received response byte.

Function
REQ-011 SHALL frame every UART byte as: start bit 0, 8 data bits LSB first, stop bit 1; each bit BAUD_DIV clocks.
REQ-012 SHALL, when snd_cmd=1 in IDLE, latch cmd that cycle; later changes to cmd shall not affect the transfer.
REQ-013 SHALL use states IDLE -> SEND_HI -> WAIT_HI -> SEND_LO -> WAIT_LO -> IDLE, and shall transmit cmd[15:8] first, then cmd[7:0], back-to-back with no idle gap.
REQ-014 SHALL pulse cmd_snt for exactly 1 cycle, in the cycle after the low byte's stop bit completes (20*BAUD_DIV+2 clocks after snd_cmd, tolerance +-2).
REQ-015 SHALL ignore snd_cmd while not in IDLE; no queuing.
REQ-016 SHALL pass RX through a 2-flop synchronizer and detect the start bit as a synchronized high-to-low transition while the receiver is idle.
REQ-017 SHALL sample each RX bit at mid-bit (first sample BAUD_DIV/2 clocks after the start edge, then every BAUD_DIV clocks), shifting in 8 data bits plus the stop bit.
REQ-018 SHALL, at the stop-bit sample, load resp with the data byte and set resp_rdy=1 the next cycle.
REQ-019 SHALL clear resp_rdy on the next detected start bit or on an accepted snd_cmd, whichever comes first; resp holds its value until overwritten.
REQ-020 SHALL run transmitter and receiver independently, so a response received during a command transmission is captured correctly.
REQ-021 SHALL size all baud counters as $clog2(BAUD_DIV)+1 bits and all bit counters as 4 bits; counters shall never wrap mid-frame.

Reset
REQ-022 SHALL, while rst=1, force TX=1, cmd_snt=0, resp_rdy=0, resp=8'h00, both FSMs idle and counters zero, effective at the next clock edge.
REQ-023 SHALL abort a frame in progress if rst is asserted mid-frame; TX shall be high from the following edge, and no cmd_snt shall be produced for the aborted command.

Configuration
REQ-024 SHALL, when REMOTE_COMM_FRAME_CHK_EN is defined, discard a received byte whose stop-bit sample is 0: resp unchanged and resp_rdy not set.
REQ-025 SHALL, when REMOTE_COMM_FRAME_CHK_EN is undefined, accept every received byte regardless of the stop-bit value.

Structure
REQ-026 SHALL place in package remote_comm_pkg: the default BAUD_DIV constant, the transmit-sequencer state enum typedef, and the UART bit-count constant (10).
REQ-027 SHALL implement the byte-level UART transmitter and receiver in one sub-module, remote_comm_uart; remote_comm holds the two-byte sequencer and the resp_rdy and resp logic.

Verification
REQ-028 SHALL check: snd_cmd with cmd=16'h2000 -> TX carries 0x20 then 0x00; cmd_snt pulses once at about 52082 clocks (BAUD_DIV=2604).
REQ-029 SHALL check: cmd=16'h4BF2 followed by a second snd_cmd with cmd=16'h6042 issued mid-transfer -> only 0x4B, 0xF2 are sent; a single cmd_snt pulse.
REQ-030 SHALL check: model drives byte 0xA5 on RX -> resp_rdy=1 and resp=8'hA5 within 10*BAUD_DIV+4 clocks of the start edge; resp_rdy clears on the next accepted snd_cmd.
REQ-031 SHALL check: rst=1 halfway through the high byte -> TX=1 next cycle, cmd_snt stays 0, resp_rdy=0.
REQ-032 SHALL check: RX frame 0x5A sent with stop bit 0 -> with REMOTE_COMM_FRAME_CHK_EN, resp_rdy stays 0; without it, resp=8'h5A.
REQ-033 SHALL check: response 0xA5 arriving while cmd 16'h6042 is transmitting -> both cmd_snt and resp=8'hA5 occur correctly.
